// File: rtl/mux4096_burst_reader.sv
// mux4096_burst_reader
// Burst read controller placed directly after the 4096-to-1 read mux.
// It accepts (start address, beats-1) requests, steps the mux select once
// per beat and returns each selected word from an output register, with a
// valid/ready handshake and a last-beat flag.
//
// Optional build macro: MUXRD_BOUND_EN
//   undefined : burst addresses wrap modulo 2**ADDR_W, no err_o port.
//   defined   : a burst that would run past the top entry stops at it. That
//               beat is flagged last and err_o is raised. err_o stays high
//               until the next request is accepted.
module mux4096_burst_reader #(
  parameter int n      = 4,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic [ADDR_W-1:0] mux_sel_o,
  input  logic [n-1:0]      mux_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [n-1:0]      rd_data_o,
  output logic              rd_last_o,
  output logic              busy_o
`ifdef MUXRD_BOUND_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [n-1:0]      data_reg;
  logic              valid_reg;
  logic              last_reg;

  logic              in_burst;
  logic              accept;
  logic              slot_free;
  logic              load_beat;
  logic              cnt_zero;
  logic              final_beat;

  assign in_burst  = (state_reg == ST_BURST);
  // Requests are only taken in IDLE; a request held during BURST waits.
  assign accept    = req_valid_i && (state_reg == ST_IDLE);
  // The output register can take a new word when empty or being drained.
  assign slot_free = !valid_reg || rd_ready_i;
  assign load_beat = in_burst && slot_free;
  assign cnt_zero  = (cnt_reg == '0);

`ifdef MUXRD_BOUND_EN
  logic at_top;
  logic truncate;
  logic err_reg;

  // The top entry ends the burst early whenever beats would remain after it.
  assign at_top     = &cur_addr_reg;
  assign truncate   = at_top && !cnt_zero;
  assign final_beat = cnt_zero || at_top;

  // Sticky truncation flag, cleared when the next burst is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= 1'b0;
    end else if (load_beat && truncate) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign final_beat = cnt_zero;
`endif

  // Burst sequencing: capture the request, then advance address and count
  // only on edges where a beat actually moves into the output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      cur_addr_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cur_addr_reg <= req_addr_i;
            cnt_reg      <= req_len_i;
            state_reg    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (slot_free) begin
            if (final_beat) begin
              state_reg <= ST_IDLE;
            end else begin
              cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
              cnt_reg      <= cnt_reg - LEN_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load the mux word when the slot is free, otherwise
  // hold it until consumed, then drop valid and last.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (load_beat) begin
      data_reg  <= mux_data_i;
      valid_reg <= 1'b1;
      last_reg  <= final_beat;
    end else if (valid_reg && rd_ready_i) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign busy_o      = in_burst;
  assign mux_sel_o   = cur_addr_reg;
  assign rd_data_o   = data_reg;
  assign rd_valid_o  = valid_reg;
  assign rd_last_o   = last_reg;

endmodule

// File: tb/tb_mux4096_burst_reader.sv
// Testbench for mux4096_burst_reader: directed cases and random bursts
// against a queue-based model of the beat stream. Builds with or without
// MUXRD_BOUND_EN.
module tb_mux4096_burst_reader;

  localparam int DW    = 4;
  localparam int AW    = 12;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [AW-1:0] mux_sel;
  logic [DW-1:0] mux_data;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          err;

  logic [DW-1:0] mem [DEPTH];

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

  always #5 clk = ~clk;

  assign mux_data = mem[mux_sel];

  mux4096_burst_reader #(.n(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .mux_sel_o   (mux_sel),
    .mux_data_i  (mux_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .busy_o      (busy)
`ifdef MUXRD_BOUND_EN
    ,
    .err_o       (err)
`endif
  );

`ifndef MUXRD_BOUND_EN
  assign err = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the beats a request should produce, in order.
  task automatic push_burst(input int addr, input int len);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.addr = (addr + i) % DEPTH;
      b.data = mem[b.addr];
      b.last = (i == len);
`ifdef MUXRD_BOUND_EN
      if (b.addr == DEPTH - 1) b.last = 1'b1;
`endif
      exp_q.push_back(b);
      if (b.last) break;
    end
  endtask

  // Monitor: compare every consumed beat with the model, check that a
  // stalled beat stays put, and record accepted requests.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_data", 32'(rd_data), 32'(prev_data));
        check("stall_last", 32'(rd_last), 32'(prev_last));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", 32'(rd_data), 32'(b.data));
          check("beat_last", 32'(rd_last), 32'(b.last));
        end
        beats_seen++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
      if (req_valid && req_ready) push_burst(int'(req_addr), int'(req_len));
    end
  end

  // Random consumer backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) rd_ready = ($urandom_range(0, 9) < 7);
      else if (ready_mode == 0) rd_ready = 1'b1;
    end
  end

  // Present a request and hold it until accepted; returns 1 ns after the
  // accepting edge.
  task automatic send_req(input int addr, input int len);
    bit done = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    $display("req addr=%0d len=%0d", addr, len);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("req_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !rd_valid && !busy) done = 1;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_last", 32'(rd_last), 32'd0);
    check("rst_sel", 32'(mux_sel), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

    // Reset, then a single-beat burst with latency checks.
    apply_reset();
    send_req(5, 0);
    @(negedge clk);
    check("t1_first_cycle_valid", 32'(rd_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_sel", 32'(mux_sel), 32'd5);
    @(negedge clk);
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", 32'(rd_data), 32'(mem[5]));
    check("t1_last", 32'(rd_last), 32'd1);
    check("t1_ready_back", 32'(req_ready), 32'd1);
    wait_drain();

    // Full-rate burst.
    base = beats_seen;
    send_req(100, 3);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_valid", 32'(rd_valid), 32'd1);
      check("t2_data", 32'(rd_data), 32'(mem[100 + k]));
      check("t2_last", 32'(rd_last), 32'(k == 3));
    end
    check("t2_ready_back", 32'(req_ready), 32'd1);
    wait_drain();
    check("t2_beats", 32'(beats_seen - base), 32'd4);

    // Backpressure on the first beat for three cycles.
    ready_mode = 2;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    base = beats_seen;
    send_req(10, 2);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_data", 32'(rd_data), 32'(mem[10]));
      check("t3_hold_sel", 32'(mux_sel), 32'd11);
    end
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_drain();
    check("t3_beats", 32'(beats_seen - base), 32'd3);
    ready_mode = 0;

    // Top of the address space: wrap, or truncation with err_o.
    base = beats_seen;
    send_req(4094, 3);
`ifdef MUXRD_BOUND_EN
    @(negedge clk);
    @(negedge clk);
    check("t4_data0", 32'(rd_data), 32'(mem[4094]));
    @(negedge clk);
    check("t4_trunc_data", 32'(rd_data), 32'(mem[4095]));
    check("t4_trunc_last", 32'(rd_last), 32'd1);
    check("t4_err_set", 32'(err), 32'd1);
    check("t4_ready_back", 32'(req_ready), 32'd1);
    wait_drain();
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_beats", 32'(beats_seen - base), 32'd2);
    send_req(7, 0);
    check("t4_err_cleared", 32'(err), 32'd0);
    wait_drain();
`else
    wait_drain();
    check("t4_beats", 32'(beats_seen - base), 32'd4);
`endif

    // Reset in the middle of a long burst.
    send_req(0, 15);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_valid", 32'(rd_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    base = beats_seen;
    send_req(7, 0);
    wait_drain();
    check("t5_beats", 32'(beats_seen - base), 32'd1);

    // Random bursts with random backpressure, back to back.
    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      int a;
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(4080, 4095));
      else a = int'($urandom_range(0, 4095));
      send_req(a, int'($urandom_range(0, 20)));
    end
    wait_drain();
    ready_mode = 0;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
